ahb_lite_master: RTL
====================

Name: ahb_lite_master

Overview:
- Single-outstanding AHB-Lite initiator that turns a valid/ready command stream (read/write, address, write data) into AHB-Lite single NONSEQ word transfers.
- Drives one slave directly, such as the GPIO peripheral. It generates HSEL and a looped-back HREADY, so no external decoder or mux is needed.
- Used as the synthesizable bus front-end for software-style stimulus and for the SoC bring-up path.

Parameters:
- ADDR_W, 32, address width; HADDR[1:0] always driven 2'b00.
- DATA_W, 32, data width; HSIZE is fixed at word.

Ports:
- HCLK  in  1  system clock, rising edge
- HRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising HCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  type of the completed transfer
- rsp_rdata  out  DATA_W  read data; valid when rsp_valid && !rsp_write
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  IDLE = 2'b00, NONSEQ = 2'b10
- HWRITE  out  1  AHB write
- HSIZE  out  3  constant 3'b010
- HWDATA  out  DATA_W  write data, data phase
- HSEL  out  1  slave select
- HREADY  out  1  = HREADYOUT (combinational loop-back to the slave)
- HREADYOUT  in  1  slave ready
- HRDATA  in  DATA_W  slave read data

Behaviour:
- Reset values (asynchronous, while HRESET = 1):
  - state = IDLE; HTRANS = 2'b00; HSEL = 0; HWRITE = 0.
  - HADDR = 0; HWDATA = 0; rsp_valid = 0; rsp_write = 0; rsp_rdata = 0.
  - cmd_ready = 0 while HRESET is high.
- All bus outputs except HREADY are registered.
- States:
  - IDLE: cmd_ready = 1. On accept: HADDR <= {cmd_addr[ADDR_W-1:2], 2'b00}, HWRITE <= cmd_write, HTRANS <= NONSEQ, HSEL <= 1; wdata is latched internally; go to ADDR.
  - ADDR: exactly one cycle; HREADY = 1 is guaranteed because no prior transfer is pending. Next edge: HTRANS <= IDLE, HSEL <= 0, HWDATA <= latched wdata (writes only; HWDATA is held otherwise); go to DATA.
  - DATA: hold HWDATA while HREADYOUT = 0, with no limit on wait states. On the edge where HREADYOUT = 1:
    - rsp_valid <= 1, rsp_write <= HWRITE.
    - rsp_rdata <= HRDATA for reads; unchanged for writes.
    - Go to IDLE.
- Timing:
  - rsp_valid is high for exactly one cycle.
  - No back-pressure on the response; the consumer must always accept it.
  - Minimum latency: command accepted at edge N, address phase cycle N..N+1, data phase ends at edge N+2, rsp_valid high during N+2..N+3.
  - Throughput: one transfer per 3 cycles.
- Boundaries:
  - cmd_valid during ADDR or DATA: not accepted (cmd_ready = 0). Command inputs must be held stable by the source until accepted.
  - HREADYOUT low in ADDR: ignored; it only affects a previous data phase, and there is none.
  - HRESET asserted mid-transfer: the in-flight transfer is abandoned with no response pulse. The bus returns to IDLE on the same edge the reset is seen; HRESET is asynchronous to HCLK.
  - Misaligned cmd_addr: low bits silently cleared.

Optional Feature:
- Macro: AHBM_BACK2BACK_EN.
- With the macro defined:
  - cmd_ready = 1 in DATA whenever HREADYOUT = 1 (combinational).
  - A command accepted on the completing edge goes DATA -> ADDR directly. HTRANS = NONSEQ with the new HADDR appears in the cycle after completion, in parallel with rsp_valid for the old transfer.
  - Throughput becomes one transfer per 2 cycles.
- Without the macro: cmd_ready only in IDLE, as above.

Decomposition:
- Package ahbm_pkg holds:
  - typedef enum logic [1:0] htrans_t {HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10}.
  - typedef enum ahbm_state_t {IDLE, ADDR, DATA}.
  - localparam HSIZE_WORD = 3'b010.
- Single module; no sub-module is warranted.

Test Plan:
- Reset: hold HRESET 5 cycles, then release with cmd_valid = 0 -> HTRANS = 00, HSEL = 0, rsp_valid = 0, cmd_ready = 1 one cycle after release.
- Write 0x0000_0004 <= 0x0000_00A5 to a zero-wait slave:
  - NONSEQ with HWRITE = 1 for exactly 1 cycle.
  - Next cycle HWDATA = 0xA5 and HTRANS = IDLE.
  - rsp_valid with rsp_write = 1 two edges after accept.
- Read 0x0000_0000 with the slave returning 0x1234_5678 and 3 wait states (HREADYOUT low 3 cycles) -> HWDATA and HADDR stable throughout; rsp_rdata = 0x1234_5678 with rsp_valid 5 edges after accept.
- Misaligned read at 0x0000_0007 -> HADDR = 0x0000_0004.
- cmd_valid held high continuously for 4 commands -> 4 rsp_valid pulses spaced 3 cycles apart (2 cycles with AHBM_BACK2BACK_EN); no command lost or duplicated.
- HRESET pulsed during a wait-stated DATA phase -> HTRANS = 00 and HSEL = 0 immediately, no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/ahb_lite_master_pkg.sv
// Shared types and constants for the single-outstanding AHB-Lite initiator.
package ahbm_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } ahbm_state_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Command/response stream plus AHB-Lite bus signals of ahb_lite_master.
interface ahb_lite_master_if
  import ahbm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] HADDR;
  htrans_t           HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HSEL;
  logic              HREADY;
  logic              HREADYOUT;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADYOUT, HRDATA,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HSEL, HREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADYOUT, HRDATA,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HSEL, HREADY
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one NONSEQ word transfer per command.
// Define AHBM_BACK2BACK_EN to accept the next command on the completing edge.
module ahb_lite_master
  import ahbm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_lite_master_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  ahbm_state_t       state;
  ahbm_state_t       state_nx;
  logic              ready;
  logic              accept;
  logic [DATA_W-1:0] wdata_p0;

  assign bus.cmd_ready = ready;
  assign bus.HREADY    = bus.HREADYOUT;
  assign bus.HSIZE     = HSIZE_WORD;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
`ifdef AHBM_BACK2BACK_EN
      DATA: ready = bus.HREADYOUT;
`endif
      default: ready = 1'b0;
    endcase
    ready  = ready & ~HRESET;
    accept = bus.cmd_valid & ready;
    case (state)
      IDLE:    if (accept) state_nx = ADDR;
      ADDR:    state_nx = DATA;
      DATA:    if (bus.HREADYOUT) state_nx = accept ? ADDR : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address phase launch, data phase drive and response capture
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      bus.HADDR     <= '0;
      bus.HTRANS    <= HTRANS_IDLE;
      bus.HWRITE    <= 1'b0;
      bus.HSEL      <= 1'b0;
      bus.HWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= '0;
      wdata_p0      <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        ADDR: begin
          bus.HTRANS <= HTRANS_IDLE;
          bus.HSEL   <= 1'b0;
          if (bus.HWRITE) bus.HWDATA <= wdata_p0;
        end
        DATA: begin
          if (bus.HREADYOUT) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_write <= bus.HWRITE;
            if (!bus.HWRITE) bus.rsp_rdata <= bus.HRDATA;
          end
        end
        default: ;
      endcase
      // A new command can overlap the completing edge in back-to-back mode
      if (accept) begin
        bus.HADDR  <= bus.cmd_addr & ALIGN_MASK;
        bus.HWRITE <= bus.cmd_write;
        bus.HTRANS <= HTRANS_NONSEQ;
        bus.HSEL   <= 1'b1;
        wdata_p0   <= bus.cmd_wdata;
      end
    end
  end

endmodule
